head_table_wr_ctrl: RTL and testbench

HEAD_TABLE_WR_CTRL -- requirements
Module: head_table_wr_ctrl

---
 rtl/head_table_if.sv | 16 +
 rtl/head_table_wr_ctrl.sv | 127 ++++++++++++
 tb/tb_head_table_wr_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/head_table_if.sv
// Write port of the bucket head table.
//   wr_en   : one write this cycle
//   wr_addr : bucket index
//   wr_data : {head pointer, pointer valid}
// master drives all three signals; slave (the table) receives them.
interface head_table_if #(
  parameter int unsigned BUCKET_WIDTH = 10,
  parameter int unsigned PTR_WIDTH    = 8
);
  logic [BUCKET_WIDTH-1:0] wr_addr;
  logic [PTR_WIDTH:0]      wr_data;
  logic                    wr_en;

  modport master (output wr_addr, output wr_data, output wr_en);
  modport slave  (input  wr_addr, input  wr_data, input  wr_en);
endinterface

// File: rtl/head_table_wr_ctrl.sv
// Head table write controller.
// Clears every table entry after reset (AUTO_INIT) or on init_i, then forwards head updates
// one per cycle to the table write port. All table-port signals come from flops.
// Ports:
//   clk_i, rst_n_i     : clock, asynchronous active-low reset
//   init_i             : pulse requesting a full table clear
//   init_done_o        : table initialised, updates accepted
//   upd_valid_i/ready_o: update handshake
//   upd_bucket_i       : bucket to write
//   upd_ptr_i          : new head pointer
//   upd_ptr_val_i      : head pointer valid (0 = empty bucket)
//   ht_if              : table write port (master)
//   wr_cnt_o           : saturating count of update writes
module head_table_wr_ctrl #(
  parameter int unsigned BUCKET_WIDTH = 10,
  parameter int unsigned PTR_WIDTH    = 8,
  parameter bit          AUTO_INIT    = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    init_i,
  output logic                    init_done_o,
  input  logic                    upd_valid_i,
  output logic                    upd_ready_o,
  input  logic [BUCKET_WIDTH-1:0] upd_bucket_i,
  input  logic [PTR_WIDTH-1:0]    upd_ptr_i,
  input  logic                    upd_ptr_val_i,
  head_table_if.master            ht_if,
  output logic [31:0]             wr_cnt_o
);

  // One extra bit so the sweep end (2^BUCKET_WIDTH) is seen without wrapping to 0.
  localparam int unsigned CntW = BUCKET_WIDTH + 1;

  typedef enum logic [1:0] {StIdle, StClear, StRun} state_e;

  state_e                  state_q, state_d;
  logic [CntW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                    auto_q;
  logic                    wr_en_q, wr_en_d;
  logic [BUCKET_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [PTR_WIDTH:0]      wr_data_q, wr_data_d;
  logic [31:0]             wr_cnt_q, wr_cnt_d;
  logic                    start_clear;

  assign upd_ready_o = (state_q == StRun) && !init_i;
  assign init_done_o = (state_q == StRun);
  assign wr_cnt_o    = wr_cnt_q;

  assign ht_if.wr_en   = wr_en_q;
  assign ht_if.wr_addr = wr_addr_q;
  assign ht_if.wr_data = wr_data_q;

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_cnt_d    = wr_cnt_q;
    start_clear = 1'b0;

    case (state_q)
      StIdle: begin
        // auto_q is high only on the first cycle out of reset
        if (init_i || auto_q) begin
          start_clear = 1'b1;
        end
      end
      StClear: begin
        if (init_i) begin
          start_clear = 1'b1;
        end else if (clr_cnt_q[BUCKET_WIDTH]) begin
          state_d = StRun;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q[BUCKET_WIDTH-1:0];
          wr_data_d = '0;
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (init_i) begin
          start_clear = 1'b1;
        end else if (upd_valid_i) begin
          wr_en_d   = 1'b1;
          wr_addr_d = upd_bucket_i;
          wr_data_d = {upd_ptr_i, upd_ptr_val_i};
          if (wr_cnt_q != 32'hFFFF_FFFF) begin
            wr_cnt_d = wr_cnt_q + 32'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Address 0 is written on entry, so the counter resumes at 1.
    if (start_clear) begin
      state_d   = StClear;
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      wr_data_d = '0;
      clr_cnt_d = CntW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= StIdle;
      clr_cnt_q <= '0;
      auto_q    <= AUTO_INIT;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      auto_q    <= 1'b0;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

endmodule

// File: tb/tb_head_table_wr_ctrl.sv
// Testbench for head_table_wr_ctrl (BUCKET_WIDTH=4, PTR_WIDTH=8, AUTO_INIT=1).
// A transaction-level model predicts the write seen on the table port each cycle, the
// handshake and the counters; a table image built from observed writes is compared at the end
// against the contents implied by clears and last-wins updates.
module tb_head_table_wr_ctrl;
  localparam int unsigned BW = 4;
  localparam int unsigned PW = 8;
  localparam int          NB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          init = 1'b0;
  logic          valid = 1'b0;
  logic [BW-1:0] bucket = '0;
  logic [PW-1:0] ptr = '0;
  logic          pval = 1'b0;
  logic          init_done;
  logic          ready;
  logic [31:0]   wr_cnt;

  head_table_if #(.BUCKET_WIDTH(BW), .PTR_WIDTH(PW)) ht_if ();

  head_table_wr_ctrl #(.BUCKET_WIDTH(BW), .PTR_WIDTH(PW), .AUTO_INIT(1'b1)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .init_i       (init),
    .init_done_o  (init_done),
    .upd_valid_i  (valid),
    .upd_ready_o  (ready),
    .upd_bucket_i (bucket),
    .upd_ptr_i    (ptr),
    .upd_ptr_val_i(pval),
    .ht_if        (ht_if),
    .wr_cnt_o     (wr_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model state
  bit          m_done;   // table initialised
  int          m_sweep;  // next clear address, -1 when no sweep in progress
  bit          m_auto;   // clear pending from reset release
  bit          e_en;     // write expected on the port this cycle
  int          e_addr;
  int          e_data;
  logic [31:0] m_cnt;
  int          ref_tab[NB];
  int          mem[NB];

  // One clock cycle: check outputs, apply inputs, predict the next cycle.
  task automatic step(input bit i_init, input bit i_valid, input int i_bucket, input int i_ptr,
                      input bit i_pval);
    bit acc;
    @(negedge clk);
    check_eq("wr_en", ht_if.wr_en, e_en);
    if (e_en) begin
      check_eq("wr_addr", ht_if.wr_addr, e_addr);
      check_eq("wr_data", ht_if.wr_data, e_data);
      mem[ht_if.wr_addr] = ht_if.wr_data;
    end
    check_eq("init_done", init_done, m_done);
    check_eq("wr_cnt", wr_cnt, m_cnt);
    init   = i_init;
    valid  = i_valid;
    bucket = BW'(i_bucket);
    ptr    = PW'(i_ptr);
    pval   = i_pval;
    #1;
    check_eq("upd_ready", ready, m_done && !i_init);
    acc    = i_valid && m_done && !i_init;
    e_en   = 1'b0;
    if (acc) begin
      e_en   = 1'b1;
      e_addr = i_bucket;
      e_data = (i_ptr << 1) | int'(i_pval);
      ref_tab[i_bucket] = e_data;
      if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end else if (i_init || m_auto) begin
      m_done  = 1'b0;
      e_en    = 1'b1;
      e_addr  = 0;
      e_data  = 0;
      ref_tab[0] = 0;
      m_sweep = 1;
    end else if (m_sweep == NB) begin
      m_sweep = -1;
      m_done  = 1'b1;
    end else if (m_sweep > 0) begin
      e_en    = 1'b1;
      e_addr  = m_sweep;
      e_data  = 0;
      ref_tab[m_sweep] = 0;
      m_sweep++;
    end
    m_auto = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    init  = 1'b0;
    valid = 1'b0;
    #1;
    check_eq("rst_wr_en", ht_if.wr_en, 0);
    check_eq("rst_wr_addr", ht_if.wr_addr, 0);
    check_eq("rst_wr_data", ht_if.wr_data, 0);
    check_eq("rst_init_done", init_done, 0);
    check_eq("rst_upd_ready", ready, 0);
    check_eq("rst_wr_cnt", wr_cnt, 0);
    m_done  = 1'b0;
    m_sweep = -1;
    m_auto  = 1'b1;
    e_en    = 1'b0;
    m_cnt   = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < NB; i++) begin
      ref_tab[i] = -1;
      mem[i]     = -2;
    end
    #3;
    do_reset();

    // Auto clear after reset, then RUN
    repeat (18) step(0, 0, 0, 0, 0);
    check_eq("run_after_auto_clear", init_done, 1);

    // Back-to-back updates to the same bucket
    step(0, 1, 3, 'h5A, 1);
    step(0, 1, 3, 'h21, 1);
    repeat (2) step(0, 0, 0, 0, 0);
    check_eq("cnt_after_two_updates", wr_cnt, 2);
    check_eq("bucket3_last_wins", mem[3], ('h21 << 1) | 1);

    // Restart the sweep while it is at address 9
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 40 && !(e_en && e_addr == 9); k++) step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0);

    // Update valid held through a clear; first write one cycle after RUN
    step(1, 1, 5, 'h33, 1);
    repeat (20) step(0, 1, 5, $urandom_range(255), 1);

    // Update accepted, init in the next cycle
    step(0, 1, 7, 'h44, 1);
    step(1, 1, 8, 'h55, 1);
    repeat (20) step(0, 0, 0, 0, 0);

    // Asynchronous reset while the sweep is at address 6
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 40 && !(e_en && e_addr == 6); k++) step(0, 0, 0, 0, 0);
    do_reset();
    repeat (20) step(0, 0, 0, 0, 0);

    // Random traffic with occasional init pulses
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(39) == 0), ($urandom_range(9) < 7), $urandom_range(NB - 1),
           $urandom_range(255), 1'($urandom_range(1)));
    end
    repeat (20) step(0, 0, 0, 0, 0);

    // Counter saturation
    force dut.wr_cnt_q = 32'hFFFF_FFFE;
    #1 release dut.wr_cnt_q;
    m_cnt = 32'hFFFF_FFFE;
    repeat (3) step(0, 1, $urandom_range(NB - 1), $urandom_range(255), 1);
    repeat (3) step(0, 0, 0, 0, 0);
    check_eq("wr_cnt_saturated", wr_cnt, 32'hFFFF_FFFF);

    // Table image built from the port matches clear/update history
    for (int i = 0; i < NB; i++) check_eq($sformatf("table[%0d]", i), mem[i], ref_tab[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound in case a wait never returns
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
